hit_edge_collector: RTL
=======================

// Module: hit_edge_collector
// PURPOSE
//  Upstream feeder of the ball motion block. It samples per-pixel drawing requests during the raster scan.
//  It detects ball/border and ball/brick overlap and classifies each hit pixel by ball edge (Left-Top-Right-Bottom).
//  Once per frame it issues a one-cycle collision pulse with the accumulated 4-bit HitEdgeCode.
//  A frame hold-off stops a ball that is still overlapping from flipping twice.
// PARAMETERS
//  OBJECT_WIDTH   64  ball bitmap width in pixels
//  OBJECT_HEIGHT  64  ball bitmap height in pixels
//  EDGE_MARGIN    4   band in pixels from each bitmap side that counts as that edge
//  HOLDOFF_FRAMES 2   frames after a report during which hits are discarded (0 = no hold-off)
// PORTS
//  clk                  in   1   system clock
//  reset                in   1   synchronous, active-high reset
//  startOfFrame         in   1   one-cycle pulse at frame start
//  ballDrawingRequest   in   1   ball bitmap pixel is opaque at current pixel
//  ballOffsetX          in   11  pixel X offset inside ball box; valid only with ballDrawingRequest
//  ballOffsetY          in   11  pixel Y offset inside ball box; valid only with ballDrawingRequest
//  borderDrawingRequest in   1   frame border is drawn at current pixel
//  brickDrawingRequest  in   1   a brick is drawn at current pixel
//  collision            out  1   one-cycle pulse: a report is issued
//  HitEdgeCode          out  4   [3]=Left [2]=Top [1]=Right [0]=Bottom; held until next report
//  collisionBrick       out  1   pulse with collision when any hit in the frame was a brick hit
//  hitCount             out  8   saturating count of issued reports
// BEHAVIOUR
//  Interface: one clock, clk. Reset is synchronous and active-high. All outputs are registered.
//  Reset values: collision=0, HitEdgeCode=4'b0000, collisionBrick=0, hitCount=0.
//  Reset also sets: accumulator=0, brick flag=0, holdoff counter=0, state=COLLECT.
//  Hit pixel: ballDrawingRequest && (borderDrawingRequest || brickDrawingRequest).
//  Edge classification uses unsigned compares and is combinational. Several bits may be set at once (corners).
//   Left   = ballOffsetX <  EDGE_MARGIN
//   Right  = ballOffsetX >= OBJECT_WIDTH-EDGE_MARGIN
//   Top    = ballOffsetY <  EDGE_MARGIN
//   Bottom = ballOffsetY >= OBJECT_HEIGHT-EDGE_MARGIN
//  Interior hit (no edge bit set): it is ignored, and the accumulator and brick flag are unchanged.
//  FSM, 3 states:
//   COLLECT
//    - On each edge hit: accumulator |= code; brick flag |= brickDrawingRequest.
//    - On startOfFrame with accumulator != 0 and holdoff == 0:
//      load HitEdgeCode <= accumulator and collisionBrick source <= brick flag; go to REPORT.
//    - On startOfFrame otherwise: no report; if holdoff > 0, holdoff decrements.
//    - Every startOfFrame clears the accumulator and brick flag.
//   REPORT, exactly 1 cycle
//    - collision=1; collisionBrick=latched flag; hitCount += 1, saturating at 255.
//    - holdoff <= HOLDOFF_FRAMES.
//    - If HOLDOFF_FRAMES == 0, go to COLLECT; else go to HOLDOFF.
//   HOLDOFF
//    - Hit pixels are discarded.
//    - On startOfFrame: if holdoff == 1, go to COLLECT; else holdoff decrements.
//  Latency: collision asserts the cycle after the startOfFrame that closes the frame with hits.
//  Hit in the same cycle as startOfFrame: it belongs to the new frame.
//   The accumulator is cleared and then ORed with that pixel's code.
//  startOfFrame while in REPORT: it is treated as a HOLDOFF-entry frame boundary (holdoff loads HOLDOFF_FRAMES-1).
//  Reset mid-frame: the partial frame is lost. The first report is possible at the second startOfFrame after reset.
//  Brick hits at edge pixels set collisionBrick. Border-only frames report collisionBrick=0.
// STRUCTURE
//  Package hit_edge_pkg:
//   - edge_code_t (logic [3:0])
//   - EDGE_LEFT=3, EDGE_TOP=2, EDGE_RIGHT=1, EDGE_BOTTOM=0
//   - state enum {COLLECT, REPORT, HOLDOFF}
//  Shared by this block and the motion block.
//  Sub-module edge_classifier: purely combinational offsets+margins -> edge_code_t, parameterised identically.
//  Top level holds the FSM, accumulator, hold-off counter and hit counter.
// TESTING
//  1. Border hit at offset (0,30) in frame N -> the cycle after the next startOfFrame:
//     collision=1 for 1 cycle, HitEdgeCode=4'b1000, collisionBrick=0, hitCount=1.
//  2. Brick hits at (63,63) and (62,0) in one frame -> one pulse, HitEdgeCode=4'b0111, collisionBrick=1.
//  3. HOLDOFF_FRAMES=2, hits in 4 consecutive frames:
//     reports after frames 1 and 4 only; frames 2-3 are silent; hitCount=2.
//  4. Interior hit at (30,30) only -> no pulse, HitEdgeCode keeps its previous value.
//  5. Hit coincident with startOfFrame -> reported after the following frame, not the current one.
//     256 reports -> hitCount stays 255.
//  6. Assert reset mid-frame after edge hits -> all outputs 0, no pulse at the next startOfFrame.
//     Normal report at the one after.

Source files
------------

// File: rtl/hit_edge_pkg.sv
// rtl/hit_edge_pkg.sv - shared edge code, bit positions and collector states
package hit_edge_pkg;

  localparam int OFFSET_W = 11;

  typedef logic [3:0] edge_code_t;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  typedef enum logic [1:0] {
    COLLECT,
    REPORT,
    HOLDOFF
  } state_t;

endpackage

// File: rtl/edge_classifier.sv
// rtl/edge_classifier.sv - maps a ball-box pixel offset onto the ball edges it lies in
module edge_classifier
  import hit_edge_pkg::*;
#(
  parameter int OBJECT_WIDTH  = 64,
  parameter int OBJECT_HEIGHT = 64,
  parameter int EDGE_MARGIN   = 4
) (
  input  logic [OFFSET_W-1:0] offset_x,
  input  logic [OFFSET_W-1:0] offset_y,
  output edge_code_t          edge_code
);

  localparam logic [OFFSET_W-1:0] LOW_LIM    = OFFSET_W'(EDGE_MARGIN);
  localparam logic [OFFSET_W-1:0] RIGHT_LIM  = OFFSET_W'(OBJECT_WIDTH - EDGE_MARGIN);
  localparam logic [OFFSET_W-1:0] BOTTOM_LIM = OFFSET_W'(OBJECT_HEIGHT - EDGE_MARGIN);

  // Bands overlap at corners, so more than one bit may be set
  always_comb begin
    edge_code              = '0;
    edge_code[EDGE_LEFT]   = offset_x <  LOW_LIM;
    edge_code[EDGE_TOP]    = offset_y <  LOW_LIM;
    edge_code[EDGE_RIGHT]  = offset_x >= RIGHT_LIM;
    edge_code[EDGE_BOTTOM] = offset_y >= BOTTOM_LIM;
  end

endmodule

// File: rtl/hit_edge_collector.sv
// rtl/hit_edge_collector.sv - per-frame ball edge collision accumulator with hold-off
module hit_edge_collector
  import hit_edge_pkg::*;
#(
  parameter int OBJECT_WIDTH   = 64,
  parameter int OBJECT_HEIGHT  = 64,
  parameter int EDGE_MARGIN    = 4,
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                startOfFrame,
  input  logic                ballDrawingRequest,
  input  logic [OFFSET_W-1:0] ballOffsetX,
  input  logic [OFFSET_W-1:0] ballOffsetY,
  input  logic                borderDrawingRequest,
  input  logic                brickDrawingRequest,
  output logic                collision,
  output edge_code_t          HitEdgeCode,
  output logic                collisionBrick,
  output logic [7:0]          hitCount
);

  localparam logic [7:0] HOLD_LOAD    = 8'(HOLDOFF_FRAMES);
  localparam logic [7:0] HOLD_LOAD_M1 = (HOLDOFF_FRAMES > 0) ? 8'(HOLDOFF_FRAMES - 1) : 8'd0;

  state_t     state_q, state_d;
  edge_code_t hit_code;
  edge_code_t acc_q, acc_d;
  logic       brick_q, brick_d;
  logic [7:0] holdoff_q, holdoff_d;
  logic       frame_synced_q;
  logic       report_load;
  logic       accept;
  logic       edge_hit;

  edge_classifier #(
    .OBJECT_WIDTH (OBJECT_WIDTH),
    .OBJECT_HEIGHT(OBJECT_HEIGHT),
    .EDGE_MARGIN  (EDGE_MARGIN)
  ) u_classifier (
    .offset_x (ballOffsetX),
    .offset_y (ballOffsetY),
    .edge_code(hit_code)
  );

  assign edge_hit = ballDrawingRequest && (borderDrawingRequest || brickDrawingRequest)
                    && (hit_code != '0);

  always_comb begin
    state_d     = state_q;
    holdoff_d   = holdoff_q;
    report_load = 1'b0;
    case (state_q)
      COLLECT: begin
        if (startOfFrame) begin
          if ((acc_q != '0) && (holdoff_q == 8'd0)) begin
            state_d     = REPORT;
            report_load = 1'b1;
          end else if (holdoff_q != 8'd0) begin
            holdoff_d = holdoff_q - 8'd1;
          end
        end
      end
      REPORT: begin
        // A frame boundary here already consumes the first hold-off frame
        if (startOfFrame) begin
          if (HOLDOFF_FRAMES > 1) begin
            state_d   = HOLDOFF;
            holdoff_d = HOLD_LOAD_M1;
          end else begin
            state_d   = COLLECT;
            holdoff_d = 8'd0;
          end
        end else begin
          holdoff_d = HOLD_LOAD;
          state_d   = (HOLDOFF_FRAMES == 0) ? COLLECT : HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (startOfFrame) begin
          if (holdoff_q <= 8'd1) begin
            state_d   = COLLECT;
            holdoff_d = 8'd0;
          end else begin
            holdoff_d = holdoff_q - 8'd1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Hits count only toward a frame that will be collected; the partial frame after reset is dropped
  always_comb begin
    accept  = (frame_synced_q || startOfFrame)
              && ((state_d == COLLECT) || ((state_d == REPORT) && (HOLDOFF_FRAMES == 0)));
    acc_d   = startOfFrame ? '0 : acc_q;
    brick_d = startOfFrame ? 1'b0 : brick_q;
    if (accept && edge_hit) begin
      acc_d   = acc_d | hit_code;
      brick_d = brick_d | brickDrawingRequest;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= COLLECT;
      acc_q          <= '0;
      brick_q        <= 1'b0;
      holdoff_q      <= 8'd0;
      frame_synced_q <= 1'b0;
      collision      <= 1'b0;
      HitEdgeCode    <= '0;
      collisionBrick <= 1'b0;
      hitCount       <= 8'd0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      brick_q        <= brick_d;
      holdoff_q      <= holdoff_d;
      frame_synced_q <= frame_synced_q | startOfFrame;
      collision      <= report_load;
      collisionBrick <= report_load & brick_q;
      if (report_load) begin
        HitEdgeCode <= acc_q;
        hitCount    <= (hitCount != 8'hFF) ? hitCount + 8'd1 : hitCount;
      end
    end
  end

endmodule
